// File: rtl/eeprom_pkg.sv
// Shared EEPROM constants and FSM encodings for the UID checker (and the future EEPROM writer).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eeprom_pkg;

  localparam logic [7:0]  EE_CMD_READ    = 8'h03;
  localparam logic [31:0] EE_ERASED_WORD = 32'hFFFF_FFFF;
  localparam logic [7:0]  EE_DUMMY_BYTE  = 8'h00;

  // Default chip-select framing around a burst, in core clock cycles.
  localparam int EE_CS_SETUP_DEFAULT = 4;
  localparam int EE_CS_HOLD_DEFAULT  = 4;
  localparam int EE_TIMEOUT_DEFAULT  = 1024;

  // Top-level checker FSM.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SKIP     = 4'd1,
    ST_REQ      = 4'd2,
    ST_CS_SETUP = 4'd3,
    ST_CMD      = 4'd4,
    ST_ADDR_HI  = 4'd5,
    ST_ADDR_LO  = 4'd6,
    ST_READ     = 4'd7,
    ST_CS_HOLD  = 4'd8,
    ST_RELEASE  = 4'd9,
    ST_DONE     = 4'd10
  } ee_state_e;

  // Single-byte transaction FSM.
  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_ARM  = 2'd1,
    TX_WAIT = 2'd2
  } txn_state_e;

  // Chip select is low from setup through hold.
  function automatic logic ee_cs_low(input ee_state_e st);
    return (st == ST_CS_SETUP) || (st == ST_CMD) || (st == ST_ADDR_HI) ||
           (st == ST_ADDR_LO) || (st == ST_READ) || (st == ST_CS_HOLD);
  endfunction

endpackage

// File: rtl/eeprom_uid_checker_if.sv
// Arbiter handshake plus byte-level SPI master connection used by the UID checker.
// Latency: n/a (wiring only).
// Backpressure: start_xfer is only legal while xfer_active is low; grant is held while req is high.
interface eeprom_uid_checker_if;

  logic       bus_req;
  logic       bus_grant;
  logic       spi_cs_1;
  logic       start_xfer;
  logic [7:0] tx_byte;
  logic       xfer_active;
  logic       xfer_done;
  logic [7:0] rx_byte;

  modport master (
    output bus_req, spi_cs_1, start_xfer, tx_byte,
    input  bus_grant, xfer_active, xfer_done, rx_byte
  );

  modport slave (
    input  bus_req, spi_cs_1, start_xfer, tx_byte,
    output bus_grant, xfer_active, xfer_done, rx_byte
  );

endinterface

// File: rtl/eeprom_uid_checker_spi_byte_txn.sv
// One SPI byte exchange: waits for an idle master, pulses start_xfer, returns the received byte.
// Latency: start_xfer >= 1 cycle after go; done in the cycle xfer_done arrives; timeout TIMEOUT_CYCLES after start_xfer.
// Backpressure: holds off start_xfer while xfer_active is high; go is only accepted when o_idle is high.
module spi_byte_txn
  import eeprom_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = EE_TIMEOUT_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_go,
  input  logic [7:0] i_byte_in,
  output logic       o_idle,
  output logic       o_done,
  output logic [7:0] o_byte_out,
  output logic       o_timeout,
  output logic       o_start_xfer,
  output logic [7:0] o_tx_byte,
  input  logic       i_xfer_active,
  input  logic       i_xfer_done,
  input  logic [7:0] i_rx_byte
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  txn_state_e    r_state, w_state_nxt;
  logic [7:0]    r_byte;
  logic [TW-1:0] r_tmr;

  // Next state and handshake strobes.
  always_comb begin
    w_state_nxt  = r_state;
    o_start_xfer = 1'b0;
    o_done       = 1'b0;
    o_timeout    = 1'b0;
    case (r_state)
      TX_IDLE: if (i_go) w_state_nxt = TX_ARM;
      TX_ARM: begin
        if (!i_xfer_active) begin
          o_start_xfer = 1'b1;
          w_state_nxt  = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (i_xfer_done) begin
          o_done      = 1'b1;
          w_state_nxt = TX_IDLE;
        end else if (r_tmr == TMR_LAST) begin
          o_timeout   = 1'b1;
          w_state_nxt = TX_IDLE;
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  // State, latched tx byte (stable until done) and per-byte timer restarted by start_xfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= TX_IDLE;
      r_byte  <= 8'h00;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == TX_IDLE && i_go) r_byte <= i_byte_in;
      if (o_start_xfer)               r_tmr  <= '0;
      else if (r_state == TX_WAIT)    r_tmr  <= r_tmr + TW'(1);
    end
  end

  assign o_idle     = (r_state == TX_IDLE);
  assign o_tx_byte  = r_byte;
  assign o_byte_out = i_rx_byte;

endmodule

// File: rtl/eeprom_uid_checker.sv
// Looks a 32-bit card UID up in the EEPROM allow-list with a single READ burst, comparing each slot on the fly.
// Latency: erased UID done 2 cycles after start; otherwise grant wait + CS framing + (3 + 4*slots) SPI bytes.
// Backpressure: waits on bus_grant and on xfer_active before each byte; starts are ignored while busy.
module eeprom_uid_checker
  import eeprom_pkg::*;
#(
  parameter int          NUM_ENTRIES     = 16,
  parameter logic [15:0] BASE_ADDR       = 16'h0000,
  parameter int          CS_SETUP_CYCLES = EE_CS_SETUP_DEFAULT,
  parameter int          CS_HOLD_CYCLES  = EE_CS_HOLD_DEFAULT,
  parameter int          TIMEOUT_CYCLES  = EE_TIMEOUT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_check_start,
  input  logic [31:0] i_check_uid,
  output logic        o_check_busy,
  output logic        o_check_done,
  output logic        o_check_match,
  output logic [5:0]  o_check_index,
  output logic        o_check_error,
  eeprom_uid_checker_if.master bus
);

  // Setup/hold counts must be at least 1.
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD_CYCLES - 1);
  localparam logic [7:0]  LAST_BYTE  = 8'(4 * NUM_ENTRIES - 1);

  ee_state_e   r_state, w_state_nxt;
  logic [15:0] r_cnt;
  logic [7:0]  r_bcnt;
  logic [23:0] r_word;
  logic [31:0] r_uid;
  logic        r_match, r_error;
  logic [5:0]  r_index;

  logic        w_go, w_txn_idle, w_txn_done, w_txn_timeout;
  logic [7:0]  w_byte, w_rx_byte, w_tx_byte;
  logic        w_start_xfer;
  logic [31:0] w_word_nxt;
  logic        w_accept, w_set_match, w_set_error;

  assign w_accept   = (r_state == ST_IDLE) && i_check_start;
  assign w_word_nxt = {r_word, w_rx_byte};

  spi_byte_txn #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_txn (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_go         (w_go),
    .i_byte_in    (w_byte),
    .o_idle       (w_txn_idle),
    .o_done       (w_txn_done),
    .o_byte_out   (w_rx_byte),
    .o_timeout    (w_txn_timeout),
    .o_start_xfer (w_start_xfer),
    .o_tx_byte    (w_tx_byte),
    .i_xfer_active(bus.xfer_active),
    .i_xfer_done  (bus.xfer_done),
    .i_rx_byte    (bus.rx_byte)
  );

  // Sequencer: next state, byte to send, and result strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_byte      = EE_DUMMY_BYTE;
    w_set_match = 1'b0;
    w_set_error = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_check_start)
          w_state_nxt = (i_check_uid == EE_ERASED_WORD) ? ST_SKIP : ST_REQ;
      end
      ST_SKIP:     w_state_nxt = ST_DONE;
      ST_REQ:      if (bus.bus_grant) w_state_nxt = ST_CS_SETUP;
      ST_CS_SETUP: if (r_cnt == SETUP_LAST) w_state_nxt = ST_CMD;
      ST_CMD, ST_ADDR_HI, ST_ADDR_LO, ST_READ: begin
        w_go = w_txn_idle;
        case (r_state)
          ST_CMD:     w_byte = EE_CMD_READ;
          ST_ADDR_HI: w_byte = BASE_ADDR[15:8];
          ST_ADDR_LO: w_byte = BASE_ADDR[7:0];
          default:    w_byte = EE_DUMMY_BYTE;
        endcase
        if (w_txn_timeout) begin
          w_set_error = 1'b1;
          w_state_nxt = ST_CS_HOLD;
        end else if (w_txn_done) begin
          case (r_state)
            ST_CMD:     w_state_nxt = ST_ADDR_HI;
            ST_ADDR_HI: w_state_nxt = ST_ADDR_LO;
            ST_ADDR_LO: w_state_nxt = ST_READ;
            default: begin
              // Slot complete on its fourth byte: hit, erased terminator, or end of table.
              if (r_bcnt[1:0] == 2'd3) begin
                if (w_word_nxt == r_uid) begin
                  w_set_match = 1'b1;
                  w_state_nxt = ST_CS_HOLD;
                end else if (w_word_nxt == EE_ERASED_WORD || r_bcnt == LAST_BYTE) begin
                  w_state_nxt = ST_CS_HOLD;
                end
              end
            end
          endcase
        end
      end
      ST_CS_HOLD:  if (r_cnt == HOLD_LAST) w_state_nxt = ST_RELEASE;
      ST_RELEASE:  w_state_nxt = ST_DONE;
      ST_DONE:     w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Dwell counter (restarts on every state change), READ byte counter and slot shift word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= 16'd0;
      r_bcnt <= 8'd0;
      r_word <= 24'd0;
    end else begin
      r_cnt <= (w_state_nxt != r_state) ? 16'd0 : r_cnt + 16'd1;
      if (r_state != ST_READ) begin
        r_bcnt <= 8'd0;
      end else if (w_txn_done) begin
        r_bcnt <= r_bcnt + 8'd1;
        r_word <= w_word_nxt[23:0];
      end
    end
  end

  // Latched UID and results; results clear on an accepted start and hold until the next one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_uid   <= 32'd0;
      r_match <= 1'b0;
      r_index <= 6'd0;
      r_error <= 1'b0;
    end else if (w_accept) begin
      r_uid   <= i_check_uid;
      r_match <= 1'b0;
      r_index <= 6'd0;
      r_error <= 1'b0;
    end else begin
      if (w_set_match) begin
        r_match <= 1'b1;
        r_index <= r_bcnt[7:2];
      end
      if (w_set_error) begin
        r_error <= 1'b1;
        r_match <= 1'b0;
      end
    end
  end

  assign o_check_busy  = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign o_check_done  = (r_state == ST_DONE);
  assign o_check_match = r_match;
  assign o_check_index = r_index;
  assign o_check_error = r_error;

  assign bus.bus_req    = (r_state == ST_REQ) || ee_cs_low(r_state);
  assign bus.spi_cs_1   = !ee_cs_low(r_state);
  assign bus.start_xfer = w_start_xfer;
  assign bus.tx_byte    = w_tx_byte;

endmodule

// File: tb/tb_eeprom_uid_checker.sv
// Directed bench: arbiter + SPI master + EEPROM model around the UID checker, hand-computed expectations.
// Latency: model completes each byte 3 cycles after start_xfer and stays busy 4 more cycles.
// Backpressure: grant delay per test; xfer_active held past xfer_done to exercise start gating.
module tb_eeprom_uid_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_check_start;
  logic [31:0] i_check_uid;
  logic        o_check_busy, o_check_done, o_check_match, o_check_error;
  logic [5:0]  o_check_index;

  eeprom_uid_checker_if ifc();

  eeprom_uid_checker #(
    .NUM_ENTRIES    (4),
    .BASE_ADDR      (16'h0000),
    .CS_SETUP_CYCLES(4),
    .CS_HOLD_CYCLES (4),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_check_start(i_check_start),
    .i_check_uid  (i_check_uid),
    .o_check_busy (o_check_busy),
    .o_check_done (o_check_done),
    .o_check_match(o_check_match),
    .o_check_index(o_check_index),
    .o_check_error(o_check_error),
    .bus          (ifc.master)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model / monitor state
  logic [7:0] mem [0:255];
  logic [7:0] txq [$];
  int grant_delay = 0, gcnt = 0, stall_idx = -1;
  int n_start = 0, n_done = 0, n_req = 0, gate_viol = 0, nogrant_viol = 0;
  int start_cyc = 0, first_start_cyc = -1, last_start_cyc = 0, done_cyc = 0;
  int last_xd_cyc = 0, req_fall_cyc = 0, cs_rise_cyc = 0;
  logic busy_at_done = 1'b0;
  logic s_req = 1'b0, s_cs = 1'b1, s_start = 1'b0, p_req = 1'b0, p_cs = 1'b1;
  logic [7:0] s_tx = 8'h00, cur_tx = 8'h00, a_lo = 8'h00, ridx;
  int nbyte = 0, lat = 0, tail = 0;
  logic pend = 1'b0;

  // Sample outputs at negedge, drive arbiter/SPI/EEPROM responses just after posedge.
  initial begin
    ifc.bus_grant = 1'b0; ifc.xfer_active = 1'b0; ifc.xfer_done = 1'b0; ifc.rx_byte = 8'h00;
    forever begin
      @(negedge clk);
      s_req = ifc.bus_req; s_cs = ifc.spi_cs_1; s_start = ifc.start_xfer; s_tx = ifc.tx_byte;
      if (s_start) begin
        if (n_start == 0) first_start_cyc = cyc;
        n_start++; last_start_cyc = cyc; txq.push_back(s_tx);
        if (ifc.xfer_active) gate_viol++;
        if (!ifc.bus_grant) nogrant_viol++;
      end
      if (!s_cs && !ifc.bus_grant) nogrant_viol++;
      if (s_req) n_req++;
      if (o_check_done) begin n_done++; done_cyc = cyc; busy_at_done = o_check_busy; end
      if (ifc.xfer_done) last_xd_cyc = cyc;
      if (p_req && !s_req) req_fall_cyc = cyc;
      if (!p_cs && s_cs) cs_rise_cyc = cyc;
      p_req = s_req; p_cs = s_cs;

      @(posedge clk); #1;
      ifc.xfer_done = 1'b0;
      if (s_req) begin
        if (gcnt >= grant_delay) ifc.bus_grant = 1'b1; else gcnt++;
      end else begin
        ifc.bus_grant = 1'b0; gcnt = 0;
      end
      if (s_cs) nbyte = 0;
      if (s_start) begin
        pend = 1'b1; lat = 3; ifc.xfer_active = 1'b1; cur_tx = s_tx;
      end else if (pend) begin
        lat--;
        if (lat == 0) begin
          pend = 1'b0; tail = 4;
          if (nbyte != stall_idx) begin
            ridx = a_lo + 8'(nbyte - 3);
            ifc.xfer_done = 1'b1;
            ifc.rx_byte   = (nbyte >= 3) ? mem[ridx] : 8'h00;
          end
          if (nbyte == 2) a_lo = cur_tx;
          nbyte++;
        end
      end else if (tail > 0) begin
        tail--;
        if (tail == 0) ifc.xfer_active = 1'b0;
      end
    end
  end

  task automatic set_slot(input int k, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[4*k + i] = w[31 - 8*i -: 8];
  endtask

  task automatic launch(input logic [31:0] uid, input int gdel);
    grant_delay = gdel; txq.delete();
    n_start = 0; n_done = 0; n_req = 0; first_start_cyc = -1;
    @(posedge clk); #1;
    i_check_start = 1'b1; i_check_uid = uid; start_cyc = cyc;
    @(posedge clk); #1;
    i_check_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    for (int i = 0; i < bound && n_done == 0; i++) @(negedge clk);
    chk({tag, "_done_seen"}, 32'(n_done != 0), 32'd1);
    repeat (12) @(negedge clk);
  endtask

  int nz;

  initial begin
    rst = 1'b1; i_check_start = 1'b0; i_check_uid = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h5A;
    repeat (3) @(negedge clk);
    chk("rst_cs",    32'(ifc.spi_cs_1),   32'd1);
    chk("rst_req",   32'(ifc.bus_req),    32'd0);
    chk("rst_busy",  32'(o_check_busy),   32'd0);
    chk("rst_done",  32'(o_check_done),   32'd0);
    chk("rst_res",   {o_check_match, o_check_error, o_check_index}, 32'd0);
    chk("rst_start", 32'(ifc.start_xfer), 32'd0);
    chk("rst_tx",    32'(ifc.tx_byte),    32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: match in slot 2 after a 10-cycle grant delay; a start while busy is ignored
    set_slot(0, 32'h11223344); set_slot(1, 32'hCAFEF00D); set_slot(2, 32'hDEADBEEF); set_slot(3, 32'h01010101);
    launch(32'hDEADBEEF, 10);
    @(negedge clk);
    chk("t1_busy_rise", 32'(o_check_busy), 32'd1);
    repeat (20) @(negedge clk);
    @(posedge clk); #1; i_check_start = 1'b1; i_check_uid = 32'h11223344;
    @(posedge clk); #1; i_check_start = 1'b0;
    wait_done("t1", 600);
    chk("t1_ntx",   32'(txq.size()), 32'd15);
    chk("t1_cmd",   32'(txq[0]), 32'h03);
    chk("t1_ahi",   32'(txq[1]), 32'h00);
    chk("t1_alo",   32'(txq[2]), 32'h00);
    nz = 0;
    for (int i = 3; i < txq.size(); i++) if (txq[i] != 8'h00) nz++;
    chk("t1_dummy_nz", 32'(nz), 32'd0);
    chk("t1_match", 32'(o_check_match), 32'd1);
    chk("t1_index", 32'(o_check_index), 32'd2);
    chk("t1_error", 32'(o_check_error), 32'd0);
    chk("t1_ndone", 32'(n_done), 32'd1);
    chk("t1_busy_at_done", 32'(busy_at_done), 32'd0);
    // four full low cycles follow the final xfer_done, CS rises on the fifth
    chk("t1_cs_hold", 32'(cs_rise_cyc - last_xd_cyc), 32'd5);

    // 2: erased terminator in slot 3, then in slot 1
    set_slot(3, 32'hFFFFFFFF);
    launch(32'h01020304, 0);
    wait_done("t2", 600);
    chk("t2_ndata", 32'(txq.size() - 3), 32'd16);
    chk("t2_res",   {o_check_match, o_check_error, o_check_index}, 32'd0);
    set_slot(1, 32'hFFFFFFFF);
    launch(32'h01020304, 0);
    wait_done("t2b", 600);
    chk("t2b_ndata", 32'(txq.size() - 3), 32'd8);
    chk("t2b_match", 32'(o_check_match), 32'd0);

    // 3: full table, no hit; then hit in the last slot
    set_slot(0, 32'h10000001); set_slot(1, 32'h20000002); set_slot(2, 32'h30000003); set_slot(3, 32'h40000004);
    launch(32'h50000005, 0);
    wait_done("t3", 600);
    chk("t3_ndata", 32'(txq.size() - 3), 32'd16);
    chk("t3_match", 32'(o_check_match), 32'd0);
    chk("t3_index", 32'(o_check_index), 32'd0);
    chk("t3_req_fall", 32'(done_cyc - req_fall_cyc), 32'd1);
    launch(32'h40000004, 0);
    wait_done("t3b", 600);
    chk("t3b_res", {o_check_match, o_check_error, o_check_index}, {24'd0, 1'b1, 1'b0, 6'd3});

    // 4: grant withheld for 50 cycles
    gate_viol = 0; nogrant_viol = 0;
    launch(32'h20000002, 50);
    wait_done("t4", 800);
    chk("t4_nogrant_viol", 32'(nogrant_viol), 32'd0);
    chk("t4_first_start_late", 32'(first_start_cyc - start_cyc > 50), 32'd1);
    chk("t4_gate_viol", 32'(gate_viol), 32'd0);
    chk("t4_res", {o_check_match, o_check_index}, {25'd0, 1'b1, 6'd1});

    // 5: no xfer_done for byte 5 (third data byte)
    stall_idx = 5;
    launch(32'h40000004, 0);
    wait_done("t5", 1600);
    stall_idx = -1;
    chk("t5_error", 32'(o_check_error), 32'd1);
    chk("t5_match", 32'(o_check_match), 32'd0);
    chk("t5_nstart", 32'(n_start), 32'd6);
    chk("t5_done_lat", 32'(done_cyc - last_start_cyc), 32'd1030);
    chk("t5_ndone", 32'(n_done), 32'd1);
    chk("t5_cs_req", {ifc.spi_cs_1, ifc.bus_req}, 32'b10);

    // 6: reset in the middle of READ; the new start also clears the held error
    launch(32'h40000004, 0);
    @(negedge clk);
    chk("t6_err_clr", 32'(o_check_error), 32'd0);
    for (int i = 0; i < 500 && n_start < 6; i++) @(negedge clk);
    chk("t6_in_read", 32'(n_start >= 6), 32'd1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("t6_cs",   32'(ifc.spi_cs_1), 32'd1);
    chk("t6_req",  32'(ifc.bus_req),  32'd0);
    chk("t6_busy", 32'(o_check_busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("t6_ndone", 32'(n_done), 32'd0);

    // 7: erased UID bypasses the bus
    launch(32'hFFFFFFFF, 0);
    wait_done("t7", 20);
    chk("t7_lat", 32'(done_cyc - start_cyc), 32'd2);
    chk("t7_nstart", 32'(n_start), 32'd0);
    chk("t7_nreq", 32'(n_req), 32'd0);
    chk("t7_res", {o_check_match, o_check_error}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eeprom_uid_checker.md
Name: eeprom_uid_checker

Overview:
- Consumes the 32-bit card UID from the NFC card detector and checks it against an allow-list in the SPI EEPROM on chip-select 1.
- Shares the byte-level SPI master with the NFC detector and gains the bus through a req/grant handshake with the top-level arbiter.
- Issues one READ (0x03) burst and compares each 4-byte entry on the fly.
- Reports match, slot index or error to the unlock logic.

Parameters:
- NUM_ENTRIES, 16, number of 4-byte UID slots scanned (1..64).
- BASE_ADDR, 16'h0000, EEPROM byte address of slot 0.
- CS_SETUP_CYCLES, 4, clk cycles spi_cs_1 is low before the first start_xfer.
- CS_HOLD_CYCLES, 4, clk cycles after the last xfer_done before spi_cs_1 rises.
- TIMEOUT_CYCLES, 1024, maximum wait for xfer_done per byte.

Ports:
- clk  in  1  system clock (32 MHz domain).
- rst  in  1  synchronous, active-high reset.
- check_start  in  1  one-cycle request; check_uid is sampled in the same cycle.
- check_uid  in  32  UID to look up.
- check_busy  out  1  high from the accepted start until the cycle check_done pulses.
- check_done  out  1  one-cycle completion pulse.
- check_match  out  1  result; held until the next accepted start.
- check_index  out  6  matching slot number; 0 when there is no match.
- check_error  out  1  set on a transfer timeout; held until the next accepted start.
- bus_req  out  1  request for the shared SPI master.
- bus_grant  in  1  arbiter grant.
- spi_cs_1  out  1  EEPROM chip select, active-low.
- start_xfer  out  1  one-cycle pulse to the SPI master.
- tx_byte  out  8  byte to send; stable from the start_xfer cycle until xfer_done.
- xfer_active  in  1  SPI master busy.
- xfer_done  in  1  one-cycle pulse; rx_byte is valid in that cycle.
- rx_byte  in  8  received byte.

Behaviour:
- Reset: all outputs are 0 except spi_cs_1=1. The FSM goes to IDLE and the internal counters clear.
- Reset mid-operation: spi_cs_1 goes high and bus_req goes low on the next edge. No check_done pulse is produced.
- Start acceptance: check_start is accepted only in IDLE. In any other state it is ignored.
- On an accepted start:
  - check_uid is latched.
  - check_match, check_index and check_error clear.
  - check_busy rises the next cycle.
- Special UID: check_uid=32'hFFFFFFFF (the erased pattern) skips the bus entirely. The block pulses check_done two cycles after start with match=0 and error=0.
- FSM sequence: IDLE -> REQ -> CS_SETUP -> CMD -> ADDR_HI -> ADDR_LO -> READ -> CS_HOLD -> RELEASE -> DONE -> IDLE.
- REQ: bus_req=1; wait for bus_grant. bus_req stays high through RELEASE. The arbiter guarantees grant is held while req is high.
- CS_SETUP: spi_cs_1=0; count CS_SETUP_CYCLES.
- Byte transfers:
  - start_xfer pulses only when xfer_active=0.
  - The FSM then waits for xfer_done.
  - Bytes sent, in order: 0x03, BASE_ADDR[15:8], BASE_ADDR[7:0], then 0x00 dummy bytes during READ.
- READ phase:
  - Byte counter b runs 0..4*NUM_ENTRIES-1.
  - Byte b of slot k=b/4 maps into a shift word, MSB first: b%4=0 -> [31:24], through b%4=3 -> [7:0].
  - When byte b%4=3 completes, the word is compared the same cycle.
  - Equal to the latched UID: set match=1, index=k, go to CS_HOLD.
  - Equal to 32'hFFFFFFFF: end of table; go to CS_HOLD with match=0.
  - Last slot with no hit: go to CS_HOLD with match=0.
- CS_HOLD: count CS_HOLD_CYCLES, then spi_cs_1=1.
- RELEASE: bus_req=0 for one cycle.
- DONE: check_done=1 and check_busy falls in the same cycle.
- Timeout:
  - A per-byte counter resets at each start_xfer.
  - If it reaches TIMEOUT_CYCLES without xfer_done, the block sets check_error=1 and match=0.
  - It then goes to CS_HOLD -> RELEASE -> DONE.
- Address arithmetic: the 16-bit address wraps modulo 2^16. The EEPROM's sequential read handles the rollover.
- Widths: check_index is 6 bits, covering NUM_ENTRIES up to 64. The byte counter is 8 bits.

Decomposition:
- Shared package eeprom_pkg holds:
  - EE_CMD_READ=8'h03;
  - EE_ERASED_WORD=32'hFFFFFFFF;
  - the FSM state encoding (localparams);
  - the default CS setup/hold constants, also for the future EEPROM writer.
- One sub-module is natural: spi_byte_txn. It does the start_xfer/xfer_done handshake plus the timeout, exposing go/byte_in/done/byte_out/timeout. The FSM stays in the top of the block.

Test Plan:
1. Match path: slots 0..2 = 11223344, CAFEF00D, DEADBEEF; start with DEADBEEF after a 10-cycle grant delay.
   - MOSI bytes: 03 00 00 plus 12 dummy bytes.
   - Result: match=1, index=2, one done pulse, CS high CS_HOLD cycles after the last xfer_done.
2. Erased terminator: slot 3 = FFFFFFFF; look up 01020304.
   - Exactly 16 data bytes are read, then match=0, index=0, error=0.
3. Full table, no hit: NUM_ENTRIES=4, all slots valid and different.
   - 16 data bytes read, match=0.
   - bus_req drops exactly 1 cycle before done.
4. Grant gating: bus_grant held low for 50 cycles.
   - spi_cs_1 stays 1 and there is no start_xfer until the grant.
   - start_xfer pulses still wait for xfer_active=0.
5. Timeout: the model stops returning xfer_done during byte 5.
   - After 1024 cycles: error=1, match=0, CS high, bus_req low, one done pulse.
6. Robustness:
   - check_start while busy is ignored (UID unchanged, no second done).
   - rst during READ: next cycle spi_cs_1=1, bus_req=0, no done.
   - check_uid=FFFFFFFF: done 2 cycles later with no SPI activity.
